// File: rtl/dmem_stall_controller_pkg.sv
// Shared constants and request decoding for the data-memory stall controller.
// The state encodings are shared with the hazard unit and the bench.
package dmem_stall_controller_pkg;

    localparam int WORD_SIZE = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic valid;
        logic is_write;
        logic conflict;
    } access_t;

    // A load and a store both asserted is a conflict; the store wins.
    function automatic access_t decode_access(input logic rd, input logic wr);
        access_t a;
        a.valid    = rd | wr;
        a.is_write = wr;
        a.conflict = rd & wr;
        return a;
    endfunction

endpackage

// File: rtl/dmem_stall_controller_if.sv
// Request/acknowledge bus between the stall controller and the external data memory.
// The controller is the master; the memory model or macro is the slave.
interface dmem_stall_controller_if
    import dmem_stall_controller_pkg::*;
#(
    parameter int WIDTH = WORD_SIZE
);
    logic             mem_read;
    logic             mem_write;
    logic [WIDTH-1:0] mem_address;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ack;

    modport master (
        output mem_read,
        output mem_write,
        output mem_address,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_address,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/dmem_stall_controller_sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at its all-ones value.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_stall_controller.sv
// Turns MEM-stage load/store bits into a multi-cycle memory transaction and
// freezes the pipeline until it completes; also counts stalled cycles.
module dmem_stall_controller
    import dmem_stall_controller_pkg::*;
#(
    parameter int WORD_SIZE = dmem_stall_controller_pkg::WORD_SIZE,
    parameter int TIMEOUT   = 15
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    d_readM_MEM,
    input  logic                    d_writeM_MEM,
    input  logic [WORD_SIZE-1:0]    addr_MEM,
    input  logic [WORD_SIZE-1:0]    wdata_MEM,
    output logic                    stall,
    output logic [WORD_SIZE-1:0]    MDR_MEM,
    dmem_stall_controller_if.master mem,
    output logic                    err,
    output logic [15:0]             stall_cycles
);

    logic [1:0] state;
    logic [7:0] wait_cnt;
    access_t    acc;
    logic       timeout_hit;

    assign acc = decode_access(d_readM_MEM, d_writeM_MEM);

    // The request cycle itself stalls, so the pipeline never moves past an unissued access.
    assign stall = ((state == ST_IDLE) && acc.valid) || (state == ST_REQ);

    // Fires in the TIMEOUT-th REQ cycle when no ack has arrived.
    assign timeout_hit = (({1'b0, wait_cnt} + 9'd1) == 9'(TIMEOUT));

    // NOTE: reset is synchronous, so it only takes effect at a clock edge while reset_n is low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            wait_cnt        <= '0;
            MDR_MEM         <= '0;
            mem.mem_read    <= 1'b0;
            mem.mem_write   <= 1'b0;
            mem.mem_address <= '0;
            mem.mem_wdata   <= '0;
            err             <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (acc.valid) begin
                        state           <= ST_REQ;
                        wait_cnt        <= '0;
                        mem.mem_read    <= !acc.is_write;
                        mem.mem_write   <= acc.is_write;
                        mem.mem_address <= addr_MEM;
                        mem.mem_wdata   <= wdata_MEM;
                        if (acc.conflict) begin
                            err <= 1'b1;
                        end
                    end
                end

                ST_REQ: begin
                    if (mem.mem_ack) begin
                        if (!mem.mem_write) begin
                            MDR_MEM <= mem.mem_rdata;
                        end
                        mem.mem_read  <= 1'b0;
                        mem.mem_write <= 1'b0;
                        state         <= ST_DONE;
                    end else if (timeout_hit) begin
                        if (!mem.mem_write) begin
                            MDR_MEM <= '1;
                        end
                        err           <= 1'b1;
                        mem.mem_read  <= 1'b0;
                        mem.mem_write <= 1'b0;
                        state         <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                // The completing instruction's request bits are still visible here; ignore them.
                ST_DONE: state <= ST_IDLE;

                default: state <= ST_IDLE;
            endcase
        end
    end

    sat_counter #(
        .WIDTH(16)
    ) u_stall_cnt (
        .clk  (clk),
        .clr  (!reset_n),
        .en   (stall),
        .count(stall_cycles)
    );

endmodule

// File: tb/tb_dmem_stall_controller.sv
// Scoreboard bench: the driver predicts each access from a transaction-level model,
// a memory responder answers the bus, and a monitor compares every completion.
module tb_dmem_stall_controller;
    import dmem_stall_controller_pkg::*;

    localparam int W       = WORD_SIZE;
    localparam int TIMEOUT = 255;

    logic         clk;
    logic         reset_n;
    logic         d_readM_MEM;
    logic         d_writeM_MEM;
    logic [W-1:0] addr_MEM;
    logic [W-1:0] wdata_MEM;
    logic         stall;
    logic [W-1:0] MDR_MEM;
    logic         err;
    logic [15:0]  stall_cycles;

    dmem_stall_controller_if #(.WIDTH(W)) mem ();

    dmem_stall_controller #(
        .WORD_SIZE(W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .d_readM_MEM (d_readM_MEM),
        .d_writeM_MEM(d_writeM_MEM),
        .addr_MEM    (addr_MEM),
        .wdata_MEM   (wdata_MEM),
        .stall       (stall),
        .MDR_MEM     (MDR_MEM),
        .mem         (mem),
        .err         (err),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           is_reset;
        int           stall_len;
        int           req_len;
        bit           is_write;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        logic [W-1:0] mdr;
        bit           err;
        int           cycles;
    } exp_t;

    typedef struct {
        int           delay;
        logic [W-1:0] rdata;
    } resp_t;

    exp_t  sb_q[$];
    resp_t resp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    // Transaction-level model state
    logic [W-1:0] m_mdr;
    bit           m_err;
    int           m_cycles;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_t e;
        m_mdr      = '0;
        m_err      = 1'b0;
        m_cycles   = 0;
        e.is_reset = 1'b1;
        e.stall_len = 0;
        e.req_len  = 0;
        e.is_write = 1'b0;
        e.addr     = '0;
        e.wdata    = '0;
        e.mdr      = '0;
        e.err      = 1'b0;
        e.cycles   = 0;
        sb_q.push_back(e);
    endtask

    task automatic drive_idle();
        d_readM_MEM  = 1'b0;
        d_writeM_MEM = 1'b0;
        addr_MEM     = W'($urandom);
        wdata_MEM    = W'($urandom);
        @(posedge clk);
        #1;
    endtask

    // delay k in 1..TIMEOUT: memory acks in the k-th request cycle; anything else: never.
    task automatic issue(input bit rd, input bit wr, input logic [W-1:0] addr,
                         input logic [W-1:0] wdata, input int delay, input logic [W-1:0] rdata);
        exp_t  e;
        resp_t r;
        bit    acked;
        int    req;
        int    n;
        acked = (delay >= 1) && (delay <= TIMEOUT);
        req   = acked ? delay : TIMEOUT;
        if (rd && !wr) m_mdr = acked ? rdata : '1;
        if ((rd && wr) || !acked) m_err = 1'b1;
        m_cycles = (m_cycles + req + 1 > 65535) ? 65535 : m_cycles + req + 1;

        e.is_reset  = 1'b0;
        e.stall_len = req + 1;
        e.req_len   = req;
        e.is_write  = wr;
        e.addr      = addr;
        e.wdata     = wdata;
        e.mdr       = m_mdr;
        e.err       = m_err;
        e.cycles    = m_cycles;
        sb_q.push_back(e);
        r.delay = delay;
        r.rdata = rdata;
        resp_q.push_back(r);

        d_readM_MEM  = rd;
        d_writeM_MEM = wr;
        addr_MEM     = addr;
        wdata_MEM    = wdata;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall && (n < TIMEOUT + 8));
        check("stall_release", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Conflicting access interrupted by reset in the same cycle as its ack.
    task automatic conflict_then_reset();
        resp_t r;
        r.delay = 2;
        r.rdata = 16'hA5A5;
        resp_q.push_back(r);
        d_readM_MEM  = 1'b1;
        d_writeM_MEM = 1'b1;
        addr_MEM     = 16'h0222;
        wdata_MEM    = 16'h7777;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        reset_n      = 1'b0;
        d_readM_MEM  = 1'b0;
        d_writeM_MEM = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Memory responder
    initial begin
        int    cnt;
        resp_t cur;
        cnt = 0;
        cur.delay = 0;
        cur.rdata = '0;
        mem.mem_ack   = 1'b0;
        mem.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem.mem_read || mem.mem_write) begin
                if (cnt == 0) begin
                    if (resp_q.size() > 0) begin
                        cur = resp_q.pop_front();
                    end else begin
                        cur.delay = 0;
                        cur.rdata = '0;
                    end
                end
                cnt++;
                mem.mem_ack   = (cnt == cur.delay);
                mem.mem_rdata = mem.mem_ack ? cur.rdata : W'($urandom);
            end else begin
                cnt = 0;
                mem.mem_ack   = ($urandom_range(0, 7) == 0);
                mem.mem_rdata = W'($urandom);
            end
        end
    end

    // Monitor: tracks each stall run and compares at the first non-stalled cycle.
    initial begin
        int           run_len;
        int           bus_len;
        int           episodes;
        bit           prev_bus;
        bit           unstable;
        bit           in_reset;
        bit           bus_wr;
        bit           bus;
        logic [W-1:0] b_addr;
        logic [W-1:0] b_wdata;
        exp_t         e;
        run_len = 0; bus_len = 0; episodes = 0;
        prev_bus = 0; unstable = 0; in_reset = 0; bus_wr = 0;
        b_addr = '0; b_wdata = '0;
        forever begin
            @(negedge clk);
            bus = mem.mem_read || mem.mem_write;
            if (!reset_n) begin
                in_reset = 1; run_len = 0; bus_len = 0; episodes = 0; unstable = 0; prev_bus = 0;
            end else if (in_reset) begin
                in_reset = 0;
                if (sb_q.size() == 0) begin
                    check("sb_underflow_reset", 32'd0, 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check("reset_item_kind", 32'(e.is_reset), 32'd1);
                    check("rst_stall", 32'(stall), 32'd0);
                    check("rst_mem_read", 32'(mem.mem_read), 32'd0);
                    check("rst_mem_write", 32'(mem.mem_write), 32'd0);
                    check("rst_mem_address", 32'(mem.mem_address), 32'(e.addr));
                    check("rst_mem_wdata", 32'(mem.mem_wdata), 32'(e.wdata));
                    check("rst_mdr", 32'(MDR_MEM), 32'(e.mdr));
                    check("rst_err", 32'(err), 32'(e.err));
                    check("rst_stall_cycles", 32'(stall_cycles), 32'(e.cycles));
                end
            end else begin
                if (stall) begin
                    run_len++;
                    if (bus) begin
                        if (!prev_bus) begin
                            episodes++;
                            bus_wr  = mem.mem_write;
                            b_addr  = mem.mem_address;
                            b_wdata = mem.mem_wdata;
                        end else if ((mem.mem_write != bus_wr) || (mem.mem_address != b_addr) ||
                                     (mem.mem_wdata != b_wdata)) begin
                            unstable = 1;
                        end
                        if (mem.mem_read && mem.mem_write) unstable = 1;
                        bus_len++;
                    end
                end else if (run_len > 0) begin
                    if (sb_q.size() == 0) begin
                        check("sb_underflow", 32'd0, 32'd1);
                    end else begin
                        e = sb_q.pop_front();
                        check("item_kind", 32'(e.is_reset), 32'd0);
                        check("stall_len", 32'(run_len), 32'(e.stall_len));
                        check("req_len", 32'(bus_len), 32'(e.req_len));
                        check("req_episodes", 32'(episodes), 32'd1);
                        check("req_is_write", 32'(bus_wr), 32'(e.is_write));
                        check("req_addr", 32'(b_addr), 32'(e.addr));
                        check("req_wdata", 32'(b_wdata), 32'(e.wdata));
                        check("req_stable", 32'(unstable), 32'd0);
                        check("done_bus_idle", 32'(bus), 32'd0);
                        check("mdr", 32'(MDR_MEM), 32'(e.mdr));
                        check("err", 32'(err), 32'(e.err));
                        check("stall_cycles", 32'(stall_cycles), 32'(e.cycles));
                    end
                    run_len = 0; bus_len = 0; episodes = 0; unstable = 0;
                end
                if (bus && !stall) check("bus_without_stall", 32'(bus), 32'd0);
                prev_bus = bus;
            end
        end
    end

    // Driver
    initial begin
        int sel;
        int delay;
        int n;
        bit rd;
        bit wr;
        reset_n      = 1'b0;
        d_readM_MEM  = 1'b0;
        d_writeM_MEM = 1'b0;
        addr_MEM     = '0;
        wdata_MEM    = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        issue(1, 0, 16'h0040, 16'h0000, 1, 16'h1234);
        issue(0, 1, 16'h0010, 16'hBEEF, 3, 16'h5555);
        issue(1, 0, 16'h0080, 16'h0000, 2, 16'hCAFE);
        issue(0, 1, 16'h0082, 16'h0BAD, 1, 16'h0000);
        issue(1, 0, 16'h0100, 16'h0000, TIMEOUT, 16'h4242);
        issue(1, 0, 16'h0200, 16'h0000, 0, 16'h0000);
        drive_idle();
        drive_idle();
        issue(0, 1, 16'h0204, 16'h3333, 2, 16'h0000);
        issue(1, 1, 16'h0300, 16'h1111, 2, 16'h9999);
        conflict_then_reset();
        issue(1, 0, 16'h0400, 16'h0000, 1, 16'h6789);

        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 3)) drive_idle();
            sel = $urandom_range(0, 15);
            rd  = (sel < 7) || (sel >= 14);
            wr  = (sel >= 7);
            delay = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 8);
            issue(rd, wr, W'($urandom), W'($urandom), delay, W'($urandom));
        end

        // Enough forced timeouts to push the stall counter past 16'hFFFF.
        for (int i = 0; i < 262; i++) begin
            issue(1, 0, W'($urandom), W'($urandom), 0, 16'h0000);
        end

        drive_idle();
        n = 0;
        while ((sb_q.size() > 0) && (n < 20)) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        miscompares++;
        $display("FAIL watchdog: time limit reached, got running, want finished");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule
